// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader sitting in front of the core's instruction fetch.
// It accepts a framed byte stream, assembles 32-bit little-endian words and
// writes them into instruction memory while the core is stalled. After a
// frame with a valid checksum, it releases the core with a one-cycle reset
// pulse so the PC restarts at 0.
//
// Frame layout:
//   SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes (LSB first), CSUM
//   CSUM = sum modulo 256 of LEN_LO, LEN_HI and every data byte.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_valid   byte available on rx_data
//   rx_data    incoming byte
//   rx_ready   loader accepts a byte (always 1 out of reset)
//   imem_we    instruction-memory write strobe, one cycle per word
//   imem_addr  word address of the write
//   imem_wdata instruction word
//   stop_en    stall request to the core PC (1 = hold)
//   core_rst   one-cycle reset pulse to the core after a good load
//   done       last frame loaded with a matching checksum
//   error      last frame rejected
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              stop_en,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [23:0]       word_lo;

  logic        xfer;
  logic [15:0] len_next;
  logic        too_long;
  logic        last_word;

  assign xfer     = rx_valid & rx_ready;
  assign len_next = {rx_data, len_lo};
  // Capacity check done in 32 bits so N == 2**ADDR_W is still accepted.
  assign too_long = 32'(len_next) > (32'd1 << ADDR_W);
  // The word being completed now is the final one of the frame.
  assign last_word = (32'(word_idx) + 32'd1) == 32'(len);

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_SYNC;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      stop_en    <= 1'b1;
      core_rst   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      len_lo     <= 8'h00;
      len        <= 16'h0000;
      csum       <= 8'h00;
      byte_idx   <= 2'd0;
      word_idx   <= '0;
      word_lo    <= 24'h00_0000;
    end else begin
      rx_ready <= 1'b1;
      // Strobes are single-cycle by construction.
      imem_we  <= 1'b0;
      core_rst <= 1'b0;

      // The cycle after the core_rst pulse releases the core, independent
      // of whether a byte arrives.
      if (state == S_DONE && core_rst) begin
        stop_en <= 1'b0;
        done    <= 1'b1;
      end

      if (xfer) begin
        case (state)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) state <= S_LEN0;
          end
          S_LEN0: begin
            len_lo <= rx_data;
            csum   <= rx_data;
            state  <= S_LEN1;
          end
          S_LEN1: begin
            len  <= len_next;
            csum <= csum + rx_data;
            if (too_long) begin
              state <= S_ERR;
              error <= 1'b1;
            end else if (len_next == 16'h0000) begin
              state <= S_CSUM;
            end else begin
              state    <= S_DATA;
              byte_idx <= 2'd0;
              word_idx <= '0;
            end
          end
          S_DATA: begin
            csum     <= csum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= rx_data;
              2'd1: word_lo[15:8]  <= rx_data;
              2'd2: word_lo[23:16] <= rx_data;
              2'd3: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx;
                imem_wdata <= {rx_data, word_lo};
                word_idx   <= word_idx + 1'b1;
                if (last_word) state <= S_CSUM;
              end
              default: word_lo <= word_lo;
            endcase
          end
          S_CSUM: begin
            if (rx_data == csum) begin
              state    <= S_DONE;
              core_rst <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          S_DONE: begin
            // A new frame re-stalls the core and withdraws done.
            if (rx_data == SYNC_BYTE) begin
              state   <= S_LEN0;
              stop_en <= 1'b1;
              done    <= 1'b0;
            end
          end
          S_ERR: begin
            if (rx_data == SYNC_BYTE) begin
              state <= S_LEN0;
              error <= 1'b0;
            end
          end
          default: begin
            state <= S_SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Frames are built from word lists; the
// reference outcome (written words, done/error/stall state, number of core
// reset pulses) is computed from the frame rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              stop_en;
  logic              core_rst;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .stop_en   (stop_en),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Captured memory writes and core reset pulses.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          crst_cnt = 0;
  logic        prev_crst = 1'b0;

  // Words of the frame under construction.
  logic [31:0] frame_words[$];

  // Monitor: record writes and check the release sequence around core_rst.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
    if (core_rst) begin
      crst_cnt++;
      chk("stall_during_crst", {31'd0, stop_en}, 32'd1);
      chk("done_during_crst", {31'd0, done}, 32'd0);
    end
    if (prev_crst && !rst) begin
      chk("crst_width", {31'd0, core_rst}, 32'd0);
      chk("release_stop", {31'd0, stop_en}, 32'd0);
      chk("release_done", {31'd0, done}, 32'd1);
    end
    prev_crst = core_rst;
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap_max);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    crst_cnt = 0;
  endtask

  // Non-sync junk bytes; the loader must discard them between frames.
  task automatic send_garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send(g, 1);
    end
  endtask

  // Sends frame_words as a frame (csum_err added to the correct checksum)
  // and checks the resulting writes and status.
  task automatic run_frame(input string tag, input logic [7:0] csum_err, input int gap_max);
    int         n;
    logic [7:0] sum;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] b;
    bit         ok;
    n   = frame_words.size();
    lo  = 8'(n);
    hi  = 8'(n >> 8);
    sum = lo + hi;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        b   = 8'(frame_words[i] >> (8 * k));
        sum = sum + b;
      end
    ok = (csum_err == 8'h00);
    clear_log();
    send(8'hA5, gap_max);
    send(lo, gap_max);
    send(hi, gap_max);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        b = 8'(frame_words[i] >> (8 * k));
        send(b, gap_max);
      end
    send(sum + csum_err, gap_max);
    idle(4);
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, wr_addr[i], 32'(i));
      chk({tag, "_data"}, wr_data[i], frame_words[i]);
    end
    chk({tag, "_done"}, {31'd0, done}, {31'd0, ok});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, !ok});
    chk({tag, "_stop"}, {31'd0, stop_en}, {31'd0, !ok});
    chk({tag, "_ncrst"}, 32'(crst_cnt), ok ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Reset state.
    chk("rst_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_stop", {31'd0, stop_en}, 32'd1);
    chk("rst_crst", {31'd0, core_rst}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);

    // Reference two-word program.
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    run_frame("t1", 8'h00, 0);

    // Wrong checksum, then the correct frame again.
    run_frame("badcs", 8'hA8, 0);
    run_frame("recover", 8'h00, 0);

    // Empty frame.
    frame_words.delete();
    run_frame("n0", 8'h00, 0);

    // N = 257 exceeds capacity: rejected right after LEN_HI.
    clear_log();
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h01, 0);
    idle(2);
    chk("big_error", {31'd0, error}, 32'd1);
    chk("big_done", {31'd0, done}, 32'd0);
    chk("big_stop", {31'd0, stop_en}, 32'd1);
    chk("big_nwr", 32'(wr_addr.size()), 32'd0);

    // Full capacity frame.
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back($urandom());
    run_frame("n256", 8'h00, 0);

    // Garbage before sync and idle gaps between bytes.
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h12, 0);
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    run_frame("gaps", 8'h00, 3);

    // Sync value embedded in data and length.
    frame_words.delete();
    for (int i = 0; i < 165; i++) frame_words.push_back(32'hA5A5_A5A5);
    run_frame("a5data", 8'h00, 0);

    // Reset after six bytes of a frame.
    clear_log();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_we", {31'd0, imem_we}, 32'd0);
    chk("mid_stop", {31'd0, stop_en}, 32'd1);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_error", {31'd0, error}, 32'd0);
    // Remaining bytes of the aborted word must be discarded.
    send(8'h00, 0);
    send(8'h93, 0);
    send(8'h00, 0);
    send(8'h10, 0);
    send(8'h00, 0);
    idle(2);
    chk("mid_nwr", 32'(wr_addr.size()), 32'd0);
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    run_frame("after_rst", 8'h00, 0);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      int         nw;
      logic [7:0] err;
      nw = $urandom_range(0, 12);
      frame_words.delete();
      for (int i = 0; i < nw; i++) frame_words.push_back($urandom());
      err = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if ($urandom_range(0, 1) == 1) send_garbage($urandom_range(1, 3));
      run_frame("rand", err, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
